ndn_rx_packet_assembler: RTL

//  Consumes the per-byte stream that the SPI receive path hands toward the FIB: meta byte, prefix bytes, data bytes.

---
 rtl/ndn_pkt_pkg.sv | 25 ++
 rtl/ndn_rx_watchdog.sv | 31 +++
 rtl/ndn_rx_packet_assembler.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/ndn_pkt_pkg.sv
// Shared types and constants for the NDN receive packet assembler.
// Holds the assembly FSM encoding, meta-byte field positions and default geometry.
package ndn_pkt_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PREFIX   = 2'd1,
        ST_DATA     = 2'd2,
        ST_COMPLETE = 2'd3
    } asm_state_t;

    localparam int META_TYPE_BIT    = 6;
    localparam int META_LEN_MSB     = 5;
    localparam int DEF_PREFIX_BYTES = 8;
    localparam int DEF_DATA_BYTES   = 32;

    // Byte counter width: large enough for the longer of the two sections.
    function automatic int byte_cnt_width(input int prefix_bytes, input int data_bytes);
        int longest;
        longest = (prefix_bytes > data_bytes) ? prefix_bytes : data_bytes;
        if (longest < 2) longest = 2;
        return $clog2(longest);
    endfunction

endpackage

// File: rtl/ndn_rx_watchdog.sv
// Inter-byte gap watchdog: counts idle cycles while a packet is being assembled and
// pulses expire on the cycle the gap reaches TIMEOUT_CYCLES.
module ndn_rx_watchdog #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic active,
    input  logic kick,
    output logic expire
);

    localparam int GAP_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [GAP_W-1:0] gap_cnt;

    // gap_cnt holds the number of idle cycles already elapsed, so the current
    // idle cycle is the last allowed one when it equals TIMEOUT_CYCLES-1.
    assign expire = active & ~kick & (gap_cnt == GAP_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gap_cnt <= '0;
        end else if (!active || kick || expire) begin
            gap_cnt <= '0;
        end else begin
            gap_cnt <= gap_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/ndn_rx_packet_assembler.sv
// Rebuilds NDN packets (meta, prefix, payload) from the SPI receive byte stream and
// holds one finished packet for the FIB lookup stage. Optional gap timeout: RX_TIMEOUT_EN.
module ndn_rx_packet_assembler
    import ndn_pkt_pkg::*;
#(
    parameter int PREFIX_BYTES   = DEF_PREFIX_BYTES,
    parameter int DATA_BYTES     = DEF_DATA_BYTES,
    parameter int CNT_W          = 8,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic                    in_sof,
    input  logic [7:0]              in_byte,
    output logic                    pkt_valid,
    input  logic                    pkt_ready,
    output logic                    pkt_is_interest,
    output logic [5:0]              pkt_prefix_len,
    output logic [PREFIX_BYTES*8-1:0] pkt_prefix,
    output logic [DATA_BYTES*8-1:0] pkt_data,
    output logic                    drop_pulse,
    output logic                    abort_pulse,
    output logic [CNT_W-1:0]        drop_count
);

    localparam int PW   = PREFIX_BYTES * 8;
    localparam int DW   = DATA_BYTES * 8;
    localparam int BC_W = byte_cnt_width(PREFIX_BYTES, DATA_BYTES);

    asm_state_t      state, state_d;
    logic [BC_W-1:0] byte_cnt;
    logic            meta_interest;
    logic [5:0]      meta_len;
    logic [PW-1:0]   prefix_sr;
    logic [DW-1:0]   data_sr;

    logic sof_in, take_meta, shift_prefix, shift_data, abort_d;
    logic prefix_last, data_last, wd_expire;
    logic complete, accept, out_load, drop_d;

    assign sof_in      = in_valid & in_sof;
    assign prefix_last = (byte_cnt == BC_W'(PREFIX_BYTES - 1));
    assign data_last   = (byte_cnt == BC_W'(DATA_BYTES - 1));
    assign accept      = pkt_valid & pkt_ready;
    assign complete    = (state == ST_COMPLETE);
    // A packet finishing while the FIB takes the held one replaces it without a drop.
    assign out_load    = complete & (~pkt_valid | accept);
    assign drop_d      = complete & pkt_valid & ~pkt_ready;

`ifdef RX_TIMEOUT_EN
    logic wd_active;
    assign wd_active = (state == ST_PREFIX) || (state == ST_DATA);

    ndn_rx_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk   (clk),
        .rst   (rst),
        .active(wd_active),
        .kick  (in_valid),
        .expire(wd_expire)
    );
`else
    assign wd_expire = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            // NOTE: state is sequential, so it takes a non-blocking assignment; the
            // combinational next-state block below uses blocking assignments instead.
            state <= state_d;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves a
        // signal unassigned, which would otherwise infer a latch.
        state_d      = state;
        take_meta    = 1'b0;
        shift_prefix = 1'b0;
        shift_data   = 1'b0;
        abort_d      = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (sof_in) begin
                    take_meta = 1'b1;
                    state_d   = ST_PREFIX;
                end
            end
            ST_PREFIX: begin
                if (sof_in) begin
                    abort_d   = 1'b1;
                    take_meta = 1'b1;
                    state_d   = ST_PREFIX;
                end else if (in_valid) begin
                    shift_prefix = 1'b1;
                    if (prefix_last) state_d = meta_interest ? ST_COMPLETE : ST_DATA;
                end else if (wd_expire) begin
                    abort_d = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_DATA: begin
                if (sof_in) begin
                    abort_d   = 1'b1;
                    take_meta = 1'b1;
                    state_d   = ST_PREFIX;
                end else if (in_valid) begin
                    shift_data = 1'b1;
                    if (data_last) state_d = ST_COMPLETE;
                end else if (wd_expire) begin
                    abort_d = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_COMPLETE: begin
                if (sof_in) begin
                    take_meta = 1'b1;
                    state_d   = ST_PREFIX;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: the wide assembly and output registers are reset on purpose: interest
    // packets must present an all-zero payload and reset must leave nothing stale.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            byte_cnt      <= '0;
            meta_interest <= 1'b0;
            meta_len      <= '0;
            prefix_sr     <= '0;
            data_sr       <= '0;
        end else if (take_meta) begin
            byte_cnt      <= '0;
            meta_interest <= in_byte[META_TYPE_BIT];
            meta_len      <= in_byte[META_LEN_MSB:0];
            prefix_sr     <= '0;
            data_sr       <= '0;
        end else if (shift_prefix) begin
            prefix_sr <= {prefix_sr[PW-9:0], in_byte};
            byte_cnt  <= prefix_last ? '0 : byte_cnt + 1'b1;
        end else if (shift_data) begin
            data_sr  <= {data_sr[DW-9:0], in_byte};
            byte_cnt <= data_last ? '0 : byte_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pkt_valid       <= 1'b0;
            pkt_is_interest <= 1'b0;
            pkt_prefix_len  <= '0;
            pkt_prefix      <= '0;
            pkt_data        <= '0;
            drop_pulse      <= 1'b0;
            abort_pulse     <= 1'b0;
            drop_count      <= '0;
        end else begin
            if (out_load) begin
                pkt_valid       <= 1'b1;
                pkt_is_interest <= meta_interest;
                pkt_prefix_len  <= meta_len;
                pkt_prefix      <= prefix_sr;
                pkt_data        <= data_sr;
            end else if (accept) begin
                pkt_valid <= 1'b0;
            end
            drop_pulse  <= drop_d;
            abort_pulse <= abort_d;
            if (drop_d && (drop_count != '1)) drop_count <= drop_count + 1'b1;
        end
    end

endmodule
